dmem_arbiter: RTL

Two-master arbiter sharing the single data-memory port (DMEM, including its memory-mapped operand/result registers) between the CPU data port (master 0) and a debug/loader port (master 1). Registered grant, per-beat ack handshake, optional locked bursts with a hard beat cap, and round-robin fairness. Sits between the CPU/loader and the DMEM instance in the SoC top.

---
 rtl/dmem_arbiter_if.sv | 11 +
 rtl/dmem_arbiter.sv | 67 ++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one master's request/ack channel into dmem_arbiter.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req, we, lock, ack;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rdata;
    modport master (output req, we, lock, addr, wdata, input ack, rdata);
    modport slave  (input req, we, lock, addr, wdata, output ack, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter for the shared DMEM port with registered grant and capped locked bursts.
// Define ARB_FIXED_PRIO_EN to make m0 win every tie instead of round-robin alternation.
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 16
) (
    input  logic          clk,
    input  logic          resetn,
    dmem_arbiter_if.slave m0,
    dmem_arbiter_if.slave m1,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    output logic [1:0]    grant,
    output logic          busy
);
    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [1:0] IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2;
    logic [1:0]    state, state_nx;
    logic [CW-1:0] beat_cnt;
    logic          g0, g1, pick1, stay;
`ifndef ARB_FIXED_PRIO_EN
    logic          last;
`endif
    assign g0 = state == GNT0;
    assign g1 = state == GNT1;
`ifdef ARB_FIXED_PRIO_EN
    assign pick1 = m1.req & ~m0.req;
`else
    assign pick1 = m1.req & (~m0.req | ~last);
`endif
    // the owner keeps the port only while requesting with lock and below the beat cap
    assign stay     = (g0 ? m0.req & m0.lock : m1.req & m1.lock) & (beat_cnt < CW'(MAX_BURST));
    assign state_nx = state == IDLE ? (pick1 ? GNT1 : m0.req ? GNT0 : IDLE) : stay ? state : IDLE;
    always_comb begin
        dmem_we    = g0 ? m0.we & m0.req : g1 ? m1.we & m1.req : 1'b0;
        dmem_addr  = g0 ? m0.addr : g1 ? m1.addr : '0;
        dmem_wdata = g0 ? m0.wdata : g1 ? m1.wdata : '0;
    end
    assign m0.ack   = g0;
    assign m1.ack   = g1;
    assign m0.rdata = g0 ? dmem_rdata : '0;
    assign m1.rdata = g1 ? dmem_rdata : '0;
    assign grant    = {g1, g0};
    assign busy     = g0 | g1;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            beat_cnt <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last     <= 1'b1;
`endif
        end else begin
            state <= state_nx;
            if (state == IDLE)
                beat_cnt <= state_nx != IDLE ? CW'(1) : beat_cnt;
            else if (stay)
                beat_cnt <= beat_cnt + CW'(1);
`ifndef ARB_FIXED_PRIO_EN
            if (state != IDLE && !stay)
                last <= g1;
`endif
        end
    end
endmodule
